// File: rtl/sum_server.sv
// Registered two-channel sum responder. A round-robin arbiter feeds a one-stage
// adder, and results leave through a source-tagged response FIFO.
module sum_server #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_op1,
  input  logic [WIDTH-1:0] a_op2,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_op1,
  input  logic [WIDTH-1:0] b_op2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             rsp_src,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = WIDTH + 2;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  src_e             last_grant;
  logic             stage_valid;
  logic [WIDTH-1:0] stage_op1;
  logic [WIDTH-1:0] stage_op2;
  src_e             stage_src;
  logic [WIDTH:0]   stage_sum;

  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [ENT_W-1:0] head;

  logic [CNT_W:0]   occupancy;
  logic             space;
  logic             push;
  logic             pop;
  logic             grant_a;
  logic             grant_b;
  logic             accept_a;
  logic             accept_b;
  logic             accept;

  // Space admits a new request when the pipeline plus FIFO can still absorb
  // it, counting a same-cycle pop as a freed slot (rsp_ready -> *_ready path).
  always_comb begin
    occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, stage_valid};
    pop       = rsp_valid && rsp_ready;
    push      = stage_valid;
    space     = (occupancy < (CNT_W+1)'(DEPTH)) ||
                ((occupancy == (CNT_W+1)'(DEPTH)) && pop);
  end

  always_comb begin
    grant_a  = a_valid && (!b_valid || (last_grant == SRC_B));
    grant_b  = b_valid && !grant_a;
    a_ready  = rst_n && space && grant_a;
    b_ready  = rst_n && space && grant_b;
    accept_a = a_valid && a_ready;
    accept_b = b_valid && b_ready;
    accept   = accept_a || accept_b;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= SRC_B;
      stage_valid <= 1'b0;
      stage_op1   <= '0;
      stage_op2   <= '0;
      stage_src   <= SRC_A;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        last_grant <= accept_a ? SRC_A : SRC_B;
        stage_src  <= accept_a ? SRC_A : SRC_B;
        stage_op1  <= accept_a ? a_op1 : b_op1;
        stage_op2  <= accept_a ? a_op2 : b_op2;
      end
    end
  end

  always_comb begin
    stage_sum = {1'b0, stage_op1} + {1'b0, stage_op2};
  end

  // FIFO storage is cleared on reset so the head reads zero while rst_n is low.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (push) begin
      fifo_mem[wr_ptr] <= {stage_sum, stage_src};
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    head      = fifo_mem[rd_ptr];
    rsp_valid = (fifo_count != '0);
    rsp_carry = head[WIDTH+1];
    rsp_sum   = head[WIDTH:1];
    rsp_src   = head[0];
    busy      = stage_valid || (fifo_count != '0);
  end

endmodule

// File: tb/tb_sum_server.sv
// Directed bench for sum_server: a vector table of single requests plus
// hand-written arbitration, back-pressure, streaming and reset sequences.
module tb_sum_server;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clock;
  logic             rst_n;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic [WIDTH-1:0] a_op1, a_op2, b_op1, b_op2;
  logic             rsp_valid, rsp_ready, rsp_carry, rsp_src, busy;
  logic [WIDTH-1:0] rsp_sum;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH+1:0] rx_q [$];

  typedef struct {
    logic       ch;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  vec_t vecs [6];

  sum_server #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_op1     (a_op1),
    .a_op2     (a_op2),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_op1     (b_op1),
    .b_op2     (b_op2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_src   (rsp_src),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Record every response handshake, sampled mid-cycle.
  always @(negedge clock) begin
    if (rst_n && rsp_valid && rsp_ready) rx_q.push_back({rsp_carry, rsp_sum, rsp_src});
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rx_q.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic rx_expect(input int idx, input int sum, input int carry, input int src);
    if (idx < rx_q.size()) begin
      chk($sformatf("rx[%0d].sum", idx), int'(rx_q[idx][WIDTH:1]), sum);
      chk($sformatf("rx[%0d].carry", idx), int'(rx_q[idx][WIDTH+1]), carry);
      chk($sformatf("rx[%0d].src", idx), int'(rx_q[idx][0]), src);
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL rx[%0d]: got none expected sum %0d", idx, sum);
    end
  endtask

  initial begin
    vecs[0] = '{ch: 1'b0, op1: 8'd3,   op2: 8'd4,   sum: 8'd7,   carry: 1'b0};
    vecs[1] = '{ch: 1'b1, op1: 8'd255, op2: 8'd1,   sum: 8'd0,   carry: 1'b1};
    vecs[2] = '{ch: 1'b0, op1: 8'd200, op2: 8'd100, sum: 8'd44,  carry: 1'b1};
    vecs[3] = '{ch: 1'b1, op1: 8'd0,   op2: 8'd0,   sum: 8'd0,   carry: 1'b0};
    vecs[4] = '{ch: 1'b0, op1: 8'd128, op2: 8'd127, sum: 8'd255, carry: 1'b0};
    vecs[5] = '{ch: 1'b1, op1: 8'd255, op2: 8'd255, sum: 8'd254, carry: 1'b1};

    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_op1 = 8'd0; a_op2 = 8'd0; b_op1 = 8'd0; b_op2 = 8'd0;
    rsp_ready = 1'b1;

    // Outputs held inactive during reset, readies forced low despite valids.
    #12;
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rsp_sum", rsp_sum, 0);
    chk("rst.a_ready", a_ready, 0);
    chk("rst.b_ready", b_ready, 0);
    do_reset();

    // Table: one isolated request per vector, consumer always ready.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].ch) begin
        b_valid = 1'b1; b_op1 = vecs[i].op1; b_op2 = vecs[i].op2;
      end else begin
        a_valid = 1'b1; a_op1 = vecs[i].op1; a_op2 = vecs[i].op2;
      end
      #1;
      chk($sformatf("v%0d.a_ready", i), a_ready, vecs[i].ch ? 0 : 1);
      chk($sformatf("v%0d.b_ready", i), b_ready, vecs[i].ch ? 1 : 0);
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      chk($sformatf("v%0d.stage_valid_early", i), rsp_valid, 0);
      tick();
      chk($sformatf("v%0d.rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d.rsp_sum", i), rsp_sum, vecs[i].sum);
      chk($sformatf("v%0d.rsp_carry", i), rsp_carry, vecs[i].carry);
      chk($sformatf("v%0d.rsp_src", i), rsp_src, vecs[i].ch);
      chk($sformatf("v%0d.busy", i), busy, 1);
      tick();
      chk($sformatf("v%0d.rsp_valid_after", i), rsp_valid, 0);
      chk($sformatf("v%0d.busy_after", i), busy, 0);
    end

    // Contention: A and B held valid, grants alternate starting with A.
    do_reset();
    rsp_ready = 1'b1;
    a_op1 = 8'd1; a_op2 = 8'd2; b_op1 = 8'd5; b_op2 = 8'd6;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d.a_ready", i), a_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d.b_ready", i), b_ready, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    wait_rx(4, 10);
    for (int i = 0; i < 4; i++) rx_expect(i, (i % 2 == 0) ? 3 : 11, 0, i % 2);

    // Back-pressure: exactly DEPTH accepts, then ready returns with the pop.
    do_reset();
    rsp_ready = 1'b0;
    a_valid = 1'b1; a_op1 = 8'd1; a_op2 = 8'd1;
    #1 chk("bp.ready1", a_ready, 1);
    tick();
    a_op1 = 8'd2; a_op2 = 8'd2;
    #1 chk("bp.ready2", a_ready, 1);
    tick();
    a_op1 = 8'd3; a_op2 = 8'd3;
    #1 chk("bp.ready3_blocked", a_ready, 0);
    tick();
    chk("bp.still_blocked", a_ready, 0);
    chk("bp.head_sum", rsp_sum, 2);
    tick();
    chk("bp.blocked_again", a_ready, 0);
    chk("bp.head_stable", rsp_sum, 2);
    chk("bp.rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    #1 chk("bp.ready_on_pop", a_ready, 1);
    tick();
    a_valid = 1'b0;
    wait_rx(3, 10);
    for (int i = 0; i < 3; i++) rx_expect(i, 2 * (i + 1), 0, 0);

    // Sustained push+pop at full occupancy: ten back-to-back accepts.
    do_reset();
    rsp_ready = 1'b0;
    a_valid = 1'b1; a_op1 = 8'd1; a_op2 = 8'd1;
    tick();
    a_op1 = 8'd2; a_op2 = 8'd2;
    tick();
    rsp_ready = 1'b1;
    for (int k = 3; k <= 12; k++) begin
      a_op1 = 8'(k); a_op2 = 8'(k);
      #1 chk($sformatf("full%0d.a_ready", k), a_ready, 1);
      tick();
    end
    a_valid = 1'b0;
    wait_rx(12, 20);
    for (int i = 0; i < 12; i++) rx_expect(i, 2 * (i + 1), 0, 0);

    // Mid-operation reset discards buffered results asynchronously.
    do_reset();
    rsp_ready = 1'b0;
    a_valid = 1'b1; a_op1 = 8'd9; a_op2 = 8'd9;
    tick();
    a_op1 = 8'd10; a_op2 = 8'd10;
    tick();
    tick();
    chk("mr.rsp_valid_before", rsp_valid, 1);
    chk("mr.busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr.rsp_valid", rsp_valid, 0);
    chk("mr.busy", busy, 0);
    chk("mr.rsp_sum", rsp_sum, 0);
    chk("mr.a_ready", a_ready, 0);
    a_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    rx_q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mr.stale%0d", i), rsp_valid, 0);
    end
    a_op1 = 8'd7; a_op2 = 8'd8; b_op1 = 8'd1; b_op2 = 8'd1;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("mr.a_wins", a_ready, 1);
    chk("mr.b_loses", b_ready, 0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    wait_rx(1, 10);
    rx_expect(0, 15, 0, 0);
    chk("mr.rx_total", rx_q.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
